cdb_broadcast_arbiter: RTL and testbench
========================================

Name: cdb_broadcast_arbiter

Overview:
- Parametrised common-data-bus arbiter for the Tomasulo core.
- Collects completed results from NUM_FU functional units (alu, brAlu, mul, div, mem) using the valid/read handshake the FUs already implement.
- Grants up to NUM_CDB results per cycle in round-robin order and broadcasts them, registered, to the reservation stations, ROB and register file.
- Replaces the single hard-wired fu1/fu2 priority mux.

Parameters:
- NUM_FU, 5, number of functional-unit result ports (>=2).
- NUM_CDB, 2, number of parallel broadcast buses (1..NUM_FU).
- DATA_WIDTH, 32, result width.
- ROB_IDX_WIDTH, 3, ROB tag width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- fu_valid_in  input  NUM_FU  FU i holds a completed result.
- fu_data_in  input  NUM_FU x DATA_WIDTH  result per FU.
- fu_rob_idx_in  input  NUM_FU x ROB_IDX_WIDTH  ROB tag per FU.
- fu_read_out  output  NUM_FU  grant; FU i's result is consumed this cycle.
- flush_in  input  1  mispredict flush; discard everything in flight.
- cdb_valid_out  output  NUM_CDB  bus k carries a valid broadcast.
- cdb_data_out  output  NUM_CDB x DATA_WIDTH  broadcast result.
- cdb_rob_idx_out  output  NUM_CDB x ROB_IDX_WIDTH  broadcast ROB tag.
- cdb_src_out  output  NUM_CDB x clog2(NUM_FU)  index of the granting FU (debug/ROB).

Behaviour:
- Reset (rst_in low, asynchronous):
  - cdb_valid_out, cdb_data_out, cdb_rob_idx_out and cdb_src_out = 0.
  - rr_ptr = 0.
  - fu_read_out = 0 while in reset.
- Grant (combinational, same cycle):
  - Scan FUs in order rr_ptr, rr_ptr+1, … mod NUM_FU.
  - The first NUM_CDB FUs with fu_valid_in=1 receive fu_read_out=1.
  - The j-th granted FU in scan order maps to bus j.
  - fu_read_out[i] is never asserted unless fu_valid_in[i]=1.
- Handshake:
  - An FU holds valid, data and tag stable until it sees read=1 at a clock edge.
  - It may drop valid the cycle after.
  - A non-granted FU keeps waiting; its result is never lost or duplicated.
- Broadcast latency:
  - Granted results appear on cdb_*_out exactly 1 cycle after the grant cycle.
  - Buses with no grant drive cdb_valid_out[k]=0; data and tag then hold their previous value (don't-care).
- Pointer update:
  - If ≥1 grant, rr_ptr ← (index of last granted FU + 1) mod NUM_FU.
  - If no grants, rr_ptr holds.
- Fairness: any FU that stays valid is granted within ceil(NUM_FU/NUM_CDB) cycles.
- Wrap-around: the scan wraps from NUM_FU-1 to 0 within a single cycle.
- Fewer valid FUs than buses: all valid FUs are granted; higher-numbered buses are idle.
- Flush:
  - flush_in=1 forces fu_read_out=0 that cycle.
  - At the next edge, cdb_valid_out ← 0; rr_ptr holds.
  - Results already registered that cycle are dropped; FUs clear themselves on the same flush.
- Reset mid-operation: in-flight broadcasts are lost. Upstream is reset together with this block.

Optional Feature:
- Macro CDB_STALL_COUNTER_EN.
- When defined:
  - Adds output stall_count_out (16 bits).
  - It increments by 1 each cycle in which at least one FU has fu_valid_in=1 and fu_read_out=0, with flush_in=0.
  - The counter saturates at 16'hFFFF.
  - Reset clears it; flush does not clear it.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package (types.svh): cdb_entry_t struct {valid, data[DATA_WIDTH], rob_idx[ROB_IDX_WIDTH], src}, plus the DATA_WIDTH and ROB_IDX_WIDTH defaults reused by the reservation stations and ROB.
- One natural sub-module, rr_multi_grant: purely combinational.
  - Inputs: request vector and rr_ptr.
  - Outputs: up to NUM_CDB one-hot grant vectors plus the next-pointer value.
- The top handles registering, flush and the counter.

Test Plan:
- Reset: rst_in low with all fu_valid_in=1 → fu_read_out=0; cdb_valid_out=2'b00 and all cdb_* outputs are 0; releasing reset leaves rr_ptr=0.
- Single result: fu_valid_in=5'b00100, fu_data_in[2]=32'hDEADBEEF, fu_rob_idx_in[2]=3'd5 → fu_read_out=5'b00100 in the same cycle; the next cycle gives cdb_valid_out=2'b01, cdb_data_out[0]=32'hDEADBEEF, cdb_rob_idx_out[0]=5, cdb_src_out[0]=2.
- Contention with round-robin: all 5 FUs valid and held → grants are {0,1}, then {2,3}, then {4,0}, then {1,2} on consecutive cycles; no FU waits more than 3 cycles.
- Wrap-around: rr_ptr=4 with fu_valid_in=5'b10001 → both granted in one cycle; bus0=FU4, bus1=FU0; rr_ptr→1.
- Flush: grant FU1 in cycle N, assert flush_in in cycle N+1 with FU3 valid → cdb_valid_out at N+1 shows FU1; at N+2 it is 0; fu_read_out[3]=0 during N+1.
- CDB_STALL_COUNTER_EN: 5 FUs valid and held for 10 cycles, NUM_CDB=2 → stall_count_out=10; then force the counter to 16'hFFFE with 3 more stall cycles → it saturates at 16'hFFFF.

Source files
------------

// File: rtl/cdb_broadcast_arbiter_pkg.sv
// Shared CDB definitions used by the arbiter, reservation stations and ROB.
// Holds the default result/tag widths, the broadcast entry type and the round-robin wrap helper.
package cdb_broadcast_arbiter_pkg;

   localparam int CDB_DATA_WIDTH    = 32;
   localparam int CDB_ROB_IDX_WIDTH = 3;
   localparam int CDB_SRC_WIDTH     = 3;

   typedef struct packed {
      logic                         valid;
      logic [CDB_DATA_WIDTH-1:0]    data;
      logic [CDB_ROB_IDX_WIDTH-1:0] rob_idx;
      logic [CDB_SRC_WIDTH-1:0]     src;
   } cdb_entry_t;

   // idx is always below 2*n, so a single conditional subtract wraps it
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage

// File: rtl/cdb_broadcast_arbiter_rr_multi_grant.sv
// Combinational round-robin picker: grants up to NUM_CDB requesters starting at ptr_i,
// the j-th winner in scan order landing on bus j, and returns the pointer after the last winner.
module cdb_broadcast_arbiter_rr_multi_grant
   import cdb_broadcast_arbiter_pkg::*;
#(
   parameter int NUM_FU  = 5,
   parameter int NUM_CDB = 2,
   parameter int SRC_W   = 3
) (
   input  logic [NUM_FU-1:0]         req_i,
   input  logic [SRC_W-1:0]          ptr_i,
   output logic [NUM_CDB*NUM_FU-1:0] gnt_onehot_o,
   output logic [NUM_CDB-1:0]        gnt_valid_o,
   output logic [NUM_CDB*SRC_W-1:0]  gnt_src_o,
   output logic [SRC_W-1:0]          next_ptr_o
);

   always_comb begin
      int cnt;
      int idx;
      int last;
      gnt_onehot_o = '0;
      gnt_valid_o  = '0;
      gnt_src_o    = '0;
      next_ptr_o   = ptr_i;
      cnt          = 0;
      idx          = 0;
      last         = 0;
      for (int s = 0; s < NUM_FU; s++) begin
         idx = rr_wrap(int'(ptr_i) + s, NUM_FU);
         for (int i = 0; i < NUM_FU; i++) begin
            if (i == idx && req_i[i] && cnt < NUM_CDB) begin
               for (int k = 0; k < NUM_CDB; k++) begin
                  if (k == cnt) begin
                     gnt_onehot_o[k*NUM_FU + i]     = 1'b1;
                     gnt_valid_o[k]                 = 1'b1;
                     gnt_src_o[k*SRC_W +: SRC_W]    = SRC_W'(i);
                  end
               end
               cnt  = cnt + 1;
               last = i;
            end
         end
      end
      if (cnt != 0) next_ptr_o = SRC_W'(rr_wrap(last + 1, NUM_FU));
   end

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// Common-data-bus arbiter: round-robin multi-grant over NUM_FU result ports onto NUM_CDB registered buses.
// Optional stall counter output enabled by defining CDB_STALL_COUNTER_EN.
module cdb_broadcast_arbiter
   import cdb_broadcast_arbiter_pkg::*;
#(
   parameter int NUM_FU        = 5,
   parameter int NUM_CDB       = 2,
   parameter int DATA_WIDTH    = CDB_DATA_WIDTH,
   parameter int ROB_IDX_WIDTH = CDB_ROB_IDX_WIDTH
) (
   input  logic                                  clk_in,
   input  logic                                  rst_in,
   input  logic [NUM_FU-1:0]                     fu_valid_in,
   input  logic [NUM_FU*DATA_WIDTH-1:0]          fu_data_in,
   input  logic [NUM_FU*ROB_IDX_WIDTH-1:0]       fu_rob_idx_in,
   output logic [NUM_FU-1:0]                     fu_read_out,
   input  logic                                  flush_in,
   output logic [NUM_CDB-1:0]                    cdb_valid_out,
   output logic [NUM_CDB*DATA_WIDTH-1:0]         cdb_data_out,
   output logic [NUM_CDB*ROB_IDX_WIDTH-1:0]      cdb_rob_idx_out,
   output logic [NUM_CDB*$clog2(NUM_FU)-1:0]     cdb_src_out
`ifdef CDB_STALL_COUNTER_EN
   ,
   output logic [15:0]                           stall_count_out
`endif
);

   localparam int SRC_W = $clog2(NUM_FU);

   logic [NUM_CDB*NUM_FU-1:0]        gnt_onehot;
   logic [NUM_CDB-1:0]               gnt_valid;
   logic [NUM_CDB*SRC_W-1:0]         gnt_src;
   logic [SRC_W-1:0]                 next_ptr;
   logic [SRC_W-1:0]                 rr_ptr_q;
   logic [NUM_FU-1:0]                read_raw;
   logic [NUM_CDB*DATA_WIDTH-1:0]    bus_data_d;
   logic [NUM_CDB*ROB_IDX_WIDTH-1:0] bus_rob_d;

   logic [NUM_CDB-1:0]               cdb_valid_q;
   logic [NUM_CDB*DATA_WIDTH-1:0]    cdb_data_q;
   logic [NUM_CDB*ROB_IDX_WIDTH-1:0] cdb_rob_q;
   logic [NUM_CDB*SRC_W-1:0]         cdb_src_q;

   cdb_broadcast_arbiter_rr_multi_grant #(
      .NUM_FU  (NUM_FU),
      .NUM_CDB (NUM_CDB),
      .SRC_W   (SRC_W)
   ) u_rr (
      .req_i        (fu_valid_in),
      .ptr_i        (rr_ptr_q),
      .gnt_onehot_o (gnt_onehot),
      .gnt_valid_o  (gnt_valid),
      .gnt_src_o    (gnt_src),
      .next_ptr_o   (next_ptr)
   );

   // One-hot grants let each bus AND-OR its source without a variable mux index
   always_comb begin
      read_raw   = '0;
      bus_data_d = '0;
      bus_rob_d  = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (gnt_onehot[k*NUM_FU + i]) begin
               read_raw[i] = 1'b1;
               bus_data_d[k*DATA_WIDTH +: DATA_WIDTH] =
                  bus_data_d[k*DATA_WIDTH +: DATA_WIDTH] | fu_data_in[i*DATA_WIDTH +: DATA_WIDTH];
               bus_rob_d[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] =
                  bus_rob_d[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] | fu_rob_idx_in[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
            end
         end
      end
   end

   assign fu_read_out = (rst_in && !flush_in) ? read_raw : '0;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cdb_valid_q <= '0;
         cdb_data_q  <= '0;
         cdb_rob_q   <= '0;
         cdb_src_q   <= '0;
         rr_ptr_q    <= '0;
      end else if (flush_in) begin
         cdb_valid_q <= '0;
      end else begin
         cdb_valid_q <= gnt_valid;
         if (|gnt_valid) rr_ptr_q <= next_ptr;
         for (int k = 0; k < NUM_CDB; k++) begin
            if (gnt_valid[k]) begin
               cdb_data_q[k*DATA_WIDTH +: DATA_WIDTH]       <= bus_data_d[k*DATA_WIDTH +: DATA_WIDTH];
               cdb_rob_q[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH]  <= bus_rob_d[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
               cdb_src_q[k*SRC_W +: SRC_W]                  <= gnt_src[k*SRC_W +: SRC_W];
            end
         end
      end
   end

   assign cdb_valid_out   = cdb_valid_q;
   assign cdb_data_out    = cdb_data_q;
   assign cdb_rob_idx_out = cdb_rob_q;
   assign cdb_src_out     = cdb_src_q;

`ifdef CDB_STALL_COUNTER_EN
   logic [15:0] stall_q;
   logic [15:0] stall_d;

   // A stall is a valid FU left waiting this cycle; flush cycles are not counted
   always_comb begin
      stall_d = stall_q;
      if (!flush_in && (|(fu_valid_in & ~fu_read_out)) && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) stall_q <= '0;
      else         stall_q <= stall_d;
   end

   assign stall_count_out = stall_q;
`endif

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Directed testbench for cdb_broadcast_arbiter (NUM_FU=5, NUM_CDB=2); covers the stall counter when CDB_STALL_COUNTER_EN is defined.
module tb_cdb_broadcast_arbiter;

   logic         clk_in = 1'b0;
   logic         rst_in;
   logic [4:0]   fu_valid_in;
   logic [159:0] fu_data_in;
   logic [14:0]  fu_rob_idx_in;
   logic [4:0]   fu_read_out;
   logic         flush_in;
   logic [1:0]   cdb_valid_out;
   logic [63:0]  cdb_data_out;
   logic [5:0]   cdb_rob_idx_out;
   logic [5:0]   cdb_src_out;
`ifdef CDB_STALL_COUNTER_EN
   logic [15:0]  stall_count_out;
`endif

   logic [31:0] d [5];
   logic [2:0]  r [5];
   int tests = 0;
   int fails = 0;

   assign fu_data_in    = {d[4], d[3], d[2], d[1], d[0]};
   assign fu_rob_idx_in = {r[4], r[3], r[2], r[1], r[0]};

   always #5 clk_in = ~clk_in;

   cdb_broadcast_arbiter dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .fu_valid_in     (fu_valid_in),
      .fu_data_in      (fu_data_in),
      .fu_rob_idx_in   (fu_rob_idx_in),
      .fu_read_out     (fu_read_out),
      .flush_in        (flush_in),
      .cdb_valid_out   (cdb_valid_out),
      .cdb_data_out    (cdb_data_out),
      .cdb_rob_idx_out (cdb_rob_idx_out),
      .cdb_src_out     (cdb_src_out)
`ifdef CDB_STALL_COUNTER_EN
      ,
      .stall_count_out (stall_count_out)
`endif
   );

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      fu_valid_in = '0;
      flush_in    = 1'b0;
      rst_in      = 1'b0;
      #2;
      rst_in      = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         d[i] = 32'hA5A5_0000 + i;
         r[i] = 3'(i);
      end
      rst_in      = 1'b0;
      flush_in    = 1'b0;
      fu_valid_in = 5'b11111;
      cyc();
      tests++; if (fu_read_out !== 5'b00000) begin fails++; $display("FAIL reset_read got=%b exp=00000", fu_read_out); end
      tests++; if (cdb_valid_out !== 2'b00) begin fails++; $display("FAIL reset_valid got=%b exp=00", cdb_valid_out); end
      tests++; if (cdb_data_out !== 64'd0) begin fails++; $display("FAIL reset_data got=%h exp=0", cdb_data_out); end
      tests++; if (cdb_rob_idx_out !== 6'd0) begin fails++; $display("FAIL reset_rob got=%h exp=0", cdb_rob_idx_out); end
      tests++; if (cdb_src_out !== 6'd0) begin fails++; $display("FAIL reset_src got=%h exp=0", cdb_src_out); end
      rst_in = 1'b1;
      #1;
      tests++; if (fu_read_out !== 5'b00011) begin fails++; $display("FAIL reset_ptr0 got=%b exp=00011", fu_read_out); end
      fu_valid_in = '0;
   endtask

   task automatic test_single();
      do_reset();
      d[2] = 32'hDEADBEEF;
      r[2] = 3'd5;
      fu_valid_in = 5'b00100;
      #1;
      tests++; if (fu_read_out !== 5'b00100) begin fails++; $display("FAIL single_read got=%b exp=00100", fu_read_out); end
      cyc();
      fu_valid_in = '0;
      tests++; if (cdb_valid_out !== 2'b01) begin fails++; $display("FAIL single_valid got=%b exp=01", cdb_valid_out); end
      tests++; if (cdb_data_out[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data got=%h exp=deadbeef", cdb_data_out[31:0]); end
      tests++; if (cdb_rob_idx_out[2:0] !== 3'd5) begin fails++; $display("FAIL single_rob got=%0d exp=5", cdb_rob_idx_out[2:0]); end
      tests++; if (cdb_src_out[2:0] !== 3'd2) begin fails++; $display("FAIL single_src got=%0d exp=2", cdb_src_out[2:0]); end
   endtask

   task automatic test_contention();
      logic [4:0] er [4];
      logic [2:0] es0 [4];
      logic [2:0] es1 [4];
      er  = '{5'b00011, 5'b01100, 5'b10001, 5'b00110};
      es0 = '{3'd0, 3'd2, 3'd4, 3'd1};
      es1 = '{3'd1, 3'd3, 3'd0, 3'd2};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         d[i] = 32'h100 + i;
         r[i] = 3'(i);
      end
      fu_valid_in = 5'b11111;
      for (int c = 0; c < 4; c++) begin
         #1;
         tests++; if (fu_read_out !== er[c]) begin fails++; $display("FAIL rr_read c%0d got=%b exp=%b", c, fu_read_out, er[c]); end
         cyc();
         tests++; if (cdb_valid_out !== 2'b11) begin fails++; $display("FAIL rr_valid c%0d got=%b exp=11", c, cdb_valid_out); end
         tests++; if (cdb_src_out[2:0] !== es0[c]) begin fails++; $display("FAIL rr_src0 c%0d got=%0d exp=%0d", c, cdb_src_out[2:0], es0[c]); end
         tests++; if (cdb_src_out[5:3] !== es1[c]) begin fails++; $display("FAIL rr_src1 c%0d got=%0d exp=%0d", c, cdb_src_out[5:3], es1[c]); end
         tests++; if (cdb_data_out[63:32] !== 32'h100 + 32'(es1[c])) begin fails++; $display("FAIL rr_data1 c%0d got=%h exp=%h", c, cdb_data_out[63:32], 32'h100 + 32'(es1[c])); end
         tests++; if (cdb_rob_idx_out[2:0] !== es0[c]) begin fails++; $display("FAIL rr_rob0 c%0d got=%0d exp=%0d", c, cdb_rob_idx_out[2:0], es0[c]); end
      end
      fu_valid_in = '0;
   endtask

   task automatic test_wrap();
      do_reset();
      fu_valid_in = 5'b01000;
      #1;
      tests++; if (fu_read_out !== 5'b01000) begin fails++; $display("FAIL wrap_pre got=%b exp=01000", fu_read_out); end
      cyc();
      fu_valid_in = 5'b10001;
      #1;
      tests++; if (fu_read_out !== 5'b10001) begin fails++; $display("FAIL wrap_read got=%b exp=10001", fu_read_out); end
      cyc();
      tests++; if (cdb_valid_out !== 2'b11) begin fails++; $display("FAIL wrap_valid got=%b exp=11", cdb_valid_out); end
      tests++; if (cdb_src_out !== {3'd0, 3'd4}) begin fails++; $display("FAIL wrap_src got=%h exp=%h", cdb_src_out, {3'd0, 3'd4}); end
      fu_valid_in = 5'b00101;
      #1;
      tests++; if (fu_read_out !== 5'b00101) begin fails++; $display("FAIL wrap_next_read got=%b exp=00101", fu_read_out); end
      cyc();
      tests++; if (cdb_src_out !== {3'd0, 3'd2}) begin fails++; $display("FAIL wrap_ptr1 got=%h exp=%h", cdb_src_out, {3'd0, 3'd2}); end
      fu_valid_in = '0;
   endtask

   task automatic test_flush();
      do_reset();
      fu_valid_in = 5'b00010;
      #1;
      tests++; if (fu_read_out !== 5'b00010) begin fails++; $display("FAIL flush_n_read got=%b exp=00010", fu_read_out); end
      cyc();
      fu_valid_in = 5'b01000;
      flush_in    = 1'b1;
      #1;
      tests++; if (cdb_valid_out !== 2'b01) begin fails++; $display("FAIL flush_n1_valid got=%b exp=01", cdb_valid_out); end
      tests++; if (cdb_src_out[2:0] !== 3'd1) begin fails++; $display("FAIL flush_n1_src got=%0d exp=1", cdb_src_out[2:0]); end
      tests++; if (fu_read_out !== 5'b00000) begin fails++; $display("FAIL flush_read got=%b exp=00000", fu_read_out); end
      cyc();
      flush_in = 1'b0;
      tests++; if (cdb_valid_out !== 2'b00) begin fails++; $display("FAIL flush_n2_valid got=%b exp=00", cdb_valid_out); end
      fu_valid_in = 5'b01001;
      #1;
      tests++; if (fu_read_out !== 5'b01001) begin fails++; $display("FAIL flush_after_read got=%b exp=01001", fu_read_out); end
      cyc();
      tests++; if (cdb_src_out !== {3'd0, 3'd3}) begin fails++; $display("FAIL flush_ptr_hold got=%h exp=%h", cdb_src_out, {3'd0, 3'd3}); end
      fu_valid_in = '0;
   endtask

`ifdef CDB_STALL_COUNTER_EN
   task automatic test_stall_counter();
      do_reset();
      tests++; if (stall_count_out !== 16'd0) begin fails++; $display("FAIL stall_reset got=%0d exp=0", stall_count_out); end
      fu_valid_in = 5'b11111;
      repeat (10) cyc();
      tests++; if (stall_count_out !== 16'd10) begin fails++; $display("FAIL stall_10 got=%0d exp=10", stall_count_out); end
      flush_in = 1'b1;
      cyc();
      flush_in = 1'b0;
      tests++; if (stall_count_out !== 16'd10) begin fails++; $display("FAIL stall_flush got=%0d exp=10", stall_count_out); end
      repeat (65524) cyc();
      tests++; if (stall_count_out !== 16'hFFFE) begin fails++; $display("FAIL stall_fffe got=%h exp=fffe", stall_count_out); end
      repeat (3) cyc();
      tests++; if (stall_count_out !== 16'hFFFF) begin fails++; $display("FAIL stall_sat got=%h exp=ffff", stall_count_out); end
      fu_valid_in = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_flush();
`ifdef CDB_STALL_COUNTER_EN
      test_stall_counter();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
